// File: rtl/regfile_dump_pkg.sv
// Shared constants and types for the register file with post-halt dump port.
//   NUM_REGS   : architectural register count (fixed at 32)
//   REG_ADDR_W : register address width
//   DATA_W     : register width
//   LAST_IDX   : index of the final dump beat
//   rf_state_t : dump sequencer states
package regfile_dump_pkg;

   localparam int NUM_REGS   = 32;
   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;

   localparam logic [REG_ADDR_W-1:0] LAST_IDX = 5'd31;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DUMP = 2'd1,
      DONE = 2'd2
   } rf_state_t;

endpackage

// File: rtl/rf_dump_fsm.sv
// Dump sequencer: freezes the register file on halt and walks the index
// counter across all registers under valid/ready flow control.
// Ports:
//   clk, rst       : clock, async active-high reset
//   halt_i         : halt request (level), only honoured in IDLE
//   dump_ready     : consumer accepts the current beat
//   frozen         : architectural writes blocked (DUMP, DONE)
//   dump_valid     : current beat valid
//   dump_idx       : register index of the current beat
//   dump_done      : all beats accepted, sticky until reset
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | normal operation, writes allowed, waiting for halt
// DUMP  | frozen, presenting beat dump_idx until accepted
// DONE  | frozen, all beats accepted, held until reset
module rf_dump_fsm
   import regfile_dump_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  halt_i,
   input  logic                  dump_ready,
   output logic                  frozen,
   output logic                  dump_valid,
   output logic [REG_ADDR_W-1:0] dump_idx,
   output logic                  dump_done
);

   rf_state_t state;

   // dump_idx doubles as the beat counter; it holds at LAST_IDX on exit
   // so it never wraps back to 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         frozen     <= 1'b0;
         dump_valid <= 1'b0;
         dump_idx   <= '0;
         dump_done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (halt_i) begin
                  state      <= DUMP;
                  frozen     <= 1'b1;
                  dump_valid <= 1'b1;
                  dump_idx   <= '0;
               end
            end
            DUMP: begin
               if (dump_valid && dump_ready) begin
                  if (dump_idx == LAST_IDX) begin
                     state      <= DONE;
                     dump_valid <= 1'b0;
                     dump_done  <= 1'b1;
                  end else begin
                     dump_idx <= dump_idx + 5'd1;
                  end
               end
            end
            DONE: begin
               frozen     <= 1'b1;
               dump_valid <= 1'b0;
               dump_done  <= 1'b1;
            end
            default: begin
               state      <= IDLE;
               frozen     <= 1'b0;
               dump_valid <= 1'b0;
               dump_idx   <= '0;
               dump_done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/regfile_dump.sv
// 32-entry register file fed by the pipeline write-back port, with two
// combinational read ports (write-to-read bypass) and a post-halt dump
// stream of all registers.
// Ports:
//   clk, rst                 : clock, async active-high reset
//   we, wAddr, wData         : write-back port
//   raddr1/rdata1            : decode read port 1
//   raddr2/rdata2            : decode read port 2
//   halt_i                   : completed break from write-back
//   dump_valid/dump_ready    : dump beat handshake
//   dump_idx/dump_data       : dump beat payload
//   dump_done                : dump complete, sticky
//   frozen                   : writes ignored while high
module regfile_dump #(
   parameter int NUM_REGS = 32,
   parameter int DATA_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [4:0]        wAddr,
   input  logic [DATA_W-1:0] wData,
   input  logic [4:0]        raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic [4:0]        raddr2,
   output logic [DATA_W-1:0] rdata2,
   input  logic              halt_i,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [4:0]        dump_idx,
   output logic [DATA_W-1:0] dump_data,
   output logic              dump_done,
   output logic              frozen
);

   import regfile_dump_pkg::*;

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic              wr_live;

   // frozen is registered, so a write presented on the halt edge still
   // commits; writes from the following cycle onward are dropped.
   assign wr_live = we && !frozen;

   rf_dump_fsm u_fsm (
      .clk        (clk),
      .rst        (rst),
      .halt_i     (halt_i),
      .dump_ready (dump_ready),
      .frozen     (frozen),
      .dump_valid (dump_valid),
      .dump_idx   (dump_idx),
      .dump_done  (dump_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_live && wAddr != '0) begin
         regs[wAddr] <= wData;
      end
   end

   always_comb begin
      rdata1 = regs[raddr1];
      if (raddr1 == '0) begin
         rdata1 = '0;
      end else if (wr_live && wAddr == raddr1) begin
         rdata1 = wData;
      end
   end

   always_comb begin
      rdata2 = regs[raddr2];
      if (raddr2 == '0) begin
         rdata2 = '0;
      end else if (wr_live && wAddr == raddr2) begin
         rdata2 = wData;
      end
   end

   // Payload is forced to 0 outside DUMP so it comes out of reset clean.
   always_comb begin
      dump_data = '0;
      if (dump_valid && dump_idx != '0) begin
         dump_data = regs[dump_idx];
      end
   end

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: random read/write traffic and dump
// streams checked against an array model of the architectural registers.
module tb_regfile_dump;

   logic        clk;
   logic        rst;
   logic        we;
   logic [4:0]  wAddr;
   logic [31:0] wData;
   logic [4:0]  raddr1;
   logic [31:0] rdata1;
   logic [4:0]  raddr2;
   logic [31:0] rdata2;
   logic        halt_i;
   logic        dump_valid;
   logic        dump_ready;
   logic [4:0]  dump_idx;
   logic [31:0] dump_data;
   logic        dump_done;
   logic        frozen;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] m_regs [32];
   bit          m_frozen;

   regfile_dump #(.NUM_REGS(32), .DATA_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .we         (we),
      .wAddr      (wAddr),
      .wData      (wData),
      .raddr1     (raddr1),
      .rdata1     (rdata1),
      .raddr2     (raddr2),
      .rdata2     (rdata2),
      .halt_i     (halt_i),
      .dump_valid (dump_valid),
      .dump_ready (dump_ready),
      .dump_idx   (dump_idx),
      .dump_data  (dump_data),
      .dump_done  (dump_done),
      .frozen     (frozen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (we && !m_frozen && wAddr == a) return wData;
      return m_regs[a];
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_frozen = 1'b0;
   endtask

   // One clock: model commits at the rising edge, inputs change at the falling edge.
   task automatic tick();
      @(posedge clk);
      if (!rst) begin
         if (we && wAddr != 5'd0 && !m_frozen) m_regs[wAddr] = wData;
         if (halt_i) m_frozen = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic rand_port_inputs();
      we     = 1'($urandom_range(0, 1));
      wAddr  = 5'($urandom);
      wData  = $urandom;
      raddr1 = ($urandom_range(0, 3) == 0) ? wAddr : 5'($urandom);
      raddr2 = ($urandom_range(0, 3) == 0) ? wAddr : 5'($urandom);
   endtask

   task automatic chk_reads(input string tag);
      chk({tag, "_rd1"}, rdata1, m_read(raddr1));
      chk({tag, "_rd2"}, rdata2, m_read(raddr2));
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_valid"}, dump_valid, 0);
      chk({tag, "_idx"},   dump_idx,   0);
      chk({tag, "_data"},  dump_data,  0);
      chk({tag, "_done"},  dump_done,  0);
      chk({tag, "_frozen"}, frozen,    0);
   endtask

   task automatic preload();
      halt_i = 1'b0;
      for (int i = 1; i < 32; i++) begin
         we    = 1'b1;
         wAddr = 5'(i);
         wData = 32'(i * 16);
         tick();
      end
      we = 1'b0;
   endtask

   // Consume beats until stop_after are accepted. Expected beat k is the
   // snapshot value of register k (x0 reads 0), in order, one per acceptance.
   task automatic run_dump(input bit bp, input int stop_after, output int accepted);
      int          cycles;
      bit          stalled [32];
      int          stall_left;
      bit          prev_stall;
      logic [4:0]  prev_i;
      logic [31:0] prev_d;
      logic [31:0] exp_d;
      cycles     = 0;
      stall_left = 0;
      prev_stall = 1'b0;
      prev_i     = '0;
      prev_d     = '0;
      accepted   = 0;
      for (int i = 0; i < 32; i++) stalled[i] = 1'b0;
      while (accepted < stop_after && cycles < 2000) begin
         if (bp) begin
            if (dump_valid && (dump_idx == 5'd0 || dump_idx == 5'd15 || dump_idx == 5'd31)
                && !stalled[dump_idx]) begin
               stalled[dump_idx] = 1'b1;
               stall_left = 3;
            end
            if (stall_left > 0) begin
               dump_ready = 1'b0;
               stall_left--;
            end else begin
               dump_ready = 1'($urandom_range(0, 1));
            end
         end else begin
            dump_ready = 1'b1;
         end
         rand_port_inputs();
         halt_i = 1'($urandom_range(0, 1));
         #1;
         if (prev_stall) begin
            chk("stall_idx",  dump_idx,  prev_i);
            chk("stall_data", dump_data, prev_d);
         end
         chk("dump_valid",  dump_valid, 1);
         chk("dump_frozen", frozen,     1);
         chk("done_early",  dump_done,  0);
         chk_reads("frozen");
         if (dump_ready) begin
            exp_d = (accepted == 0) ? 32'd0 : m_regs[accepted];
            chk("beat_idx",  dump_idx,  32'(accepted));
            chk("beat_data", dump_data, exp_d);
            accepted++;
         end
         prev_stall = !dump_ready;
         prev_i     = dump_idx;
         prev_d     = dump_data;
         tick();
         cycles++;
      end
      if (accepted < stop_after) chk("dump_timeout", 32'(accepted), 32'(stop_after));
      if (!bp && stop_after == 32) chk("full_rate_cycles", 32'(cycles), 32);
   endtask

   task automatic chk_done(input string tag);
      we = 1'b0;
      dump_ready = 1'b0;
      raddr1 = 5'd5;
      raddr2 = 5'd31;
      for (int k = 0; k < 3; k++) begin
         halt_i = 1'($urandom_range(0, 1));
         #1;
         chk({tag, "_done"},   dump_done,  1);
         chk({tag, "_valid"},  dump_valid, 0);
         chk({tag, "_frozen"}, frozen,     1);
         chk_reads(tag);
         tick();
      end
   endtask

   initial begin
      int acc;
      rst = 1'b1;
      we = 1'b0; wAddr = '0; wData = '0;
      raddr1 = 5'd7; raddr2 = 5'd0;
      halt_i = 1'b0; dump_ready = 1'b0;
      m_reset();
      #2;
      chk_idle_outputs("por");
      chk("por_rd1", rdata1, 0);
      @(negedge clk);
      rst = 1'b0;

      // write x4 with same-cycle read, then write x0
      we = 1'b1; wAddr = 5'd4; wData = 32'h1; raddr1 = 5'd4;
      #1 chk("bypass_x4", rdata1, 32'h1);
      tick();
      we = 1'b0;
      #1 chk("stored_x4", rdata1, 32'h1);
      we = 1'b1; wAddr = 5'd0; wData = 32'hFFFF_FFFF; raddr2 = 5'd0;
      #1 chk("bypass_x0", rdata2, 0);
      tick();
      we = 1'b0;
      #1 chk("stored_x0", rdata2, 0);

      repeat (150) begin
         rand_port_inputs();
         #1 chk_reads("rand");
         tick();
      end

      // halt together with a write; the next write must be dropped
      preload();
      we = 1'b1; wAddr = 5'd5; wData = 32'hDEAD_BEEF; halt_i = 1'b1;
      #1 chk("pre_halt_frozen", frozen, 0);
      tick();
      we = 1'b1; wAddr = 5'd5; wData = 32'h1; halt_i = 1'b0; raddr1 = 5'd5; dump_ready = 1'b0;
      #1;
      chk("halt_valid",  dump_valid, 1);
      chk("halt_frozen", frozen,     1);
      chk("halt_idx",    dump_idx,   0);
      chk("frozen_x5",   rdata1,     32'hDEAD_BEEF);
      tick();
      run_dump(1'b1, 32, acc);
      chk("bp_beats", 32'(acc), 32);
      chk_done("bp_done");

      // reset mid-dump after beat 10
      #2 rst = 1'b1;
      m_reset();
      @(negedge clk);
      rst = 1'b0;
      preload();
      halt_i = 1'b1;
      tick();
      halt_i = 1'b0;
      run_dump(1'b0, 11, acc);
      we = 1'b0; halt_i = 1'b0; dump_ready = 1'b0; raddr1 = 5'd10; raddr2 = 5'd3;
      #3 rst = 1'b1;
      m_reset();
      #1;
      chk_idle_outputs("abort");
      chk("abort_rd1", rdata1, 0);
      chk("abort_rd2", rdata2, 0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk_idle_outputs("post_abort");
      @(negedge clk);

      // restart from idx 0 at full rate
      preload();
      halt_i = 1'b1;
      tick();
      halt_i = 1'b0;
      run_dump(1'b0, 32, acc);
      chk("full_beats", 32'(acc), 32);
      chk_done("full_done");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
